// File: rtl/wfm_pkg.sv
// Shared definitions for the waveform drain: FSM encoding, default widths
// and the sample packing order also used by the capture block and firmware.
package wfm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   localparam int WFM_AW = 9;
   localparam int WFM_DW = 16;

   // 1: the earlier sample of a pair lands in the low half of the packed word.
   localparam bit PACK_FIRST_LOW = 1'b1;

endpackage

// File: rtl/wfm_sample_fifo.sv
// Small synchronous sample FIFO with a two-entry look-ahead so the packer can
// pop one or two samples per cycle; flush and reset clear it synchronously.
module wfm_sample_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 16
) (
   input  logic                     mem_clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     wr_en,
   input  logic [DW-1:0]            wr_data,
   input  logic [1:0]               pop,
   output logic [DW-1:0]            head0,
   output logic [DW-1:0]            head1,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [PW:0]   count_reg;

   always_ff @(posedge mem_clk) begin
      if (wr_en) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge mem_clk) begin
      if (!reset || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         rd_ptr_reg <= rd_ptr_reg + PW'(pop);
         count_reg  <= count_reg + (PW+1)'(wr_en) - (PW+1)'(pop);
      end
   end

   assign head0 = mem[rd_ptr_reg];
   assign head1 = mem[rd_ptr_reg + PW'(1)];
   assign count = count_reg;

endmodule

// File: rtl/wfm_drain.sv
// Drains a record from the capture buffer read port, packs sample pairs into
// words and streams them out with valid/ready and an end-of-record flag.
module wfm_drain
   import wfm_pkg::*;
#(
   parameter int AW         = WFM_AW,
   parameter int DW         = WFM_DW,
   parameter int FIFO_DEPTH = 4
) (
   input  logic            mem_clk,
   input  logic            reset,
   input  logic            start,
   input  logic [AW-1:0]   start_addr,
   input  logic [AW:0]     length,
   input  logic            abort,
   output logic            busy,
   output logic            done,
   output logic            ram_rd,
   output logic [AW-1:0]   ram_addr,
   input  logic [DW-1:0]   ram_data,
   output logic [2*DW-1:0] out_data,
   output logic            out_valid,
   output logic            out_last,
   input  logic            out_ready
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t          state_reg;
   state_t          state_next;
   logic            accept_start;
   logic [AW:0]     length_reg;
   logic [AW:0]     issued_reg;
   logic [AW:0]     packed_reg;
   logic [AW:0]     remaining;
   logic [AW-1:0]   addr_reg;
   logic            inflight_reg;
   logic [2*DW-1:0] out_data_reg;
   logic            out_valid_reg;
   logic            out_last_reg;
   logic [2*DW-1:0] pack_word;
   logic [DW-1:0]   second_sample;
   logic [CW-1:0]   fifo_count;
   logic [DW-1:0]   fifo_head0;
   logic [DW-1:0]   fifo_head1;
   logic [1:0]      pop;
   logic            can_pair;
   logic            can_single;
   logic            pack_load;
   logic            rd_issue;

   wfm_sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (DW)
   ) u_fifo (
      .mem_clk (mem_clk),
      .reset   (reset),
      .flush   (abort),
      .wr_en   (inflight_reg),
      .wr_data (ram_data),
      .pop     (pop),
      .head0   (fifo_head0),
      .head1   (fifo_head1),
      .count   (fifo_count)
   );

   always_ff @(posedge mem_clk) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      accept_start = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               accept_start = 1'b1;
               state_next   = (length == '0) ? ST_FIN : ST_RUN;
            end
         end
         ST_RUN: begin
            if (out_valid_reg && out_ready && out_last_reg) begin
               state_next = ST_FIN;
            end
         end
         ST_FIN:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
      if (abort) begin
         state_next   = ST_IDLE;
         accept_start = 1'b0;
      end
   end

   // Credit check counts the read still in flight so the unconditional
   // FIFO write one cycle later can never overflow.
   always_comb begin
      remaining  = length_reg - packed_reg;
      can_pair   = (remaining >= (AW+1)'(2)) && (fifo_count >= CW'(2));
      can_single = (remaining == (AW+1)'(1)) && (fifo_count != '0);
      rd_issue   = (state_reg == ST_RUN) && !abort && (issued_reg < length_reg) &&
                   (({1'b0, fifo_count} + (CW+1)'(inflight_reg)) < (CW+1)'(FIFO_DEPTH));
      pack_load  = (state_reg == ST_RUN) && !abort && (!out_valid_reg || out_ready) &&
                   (can_pair || can_single);
      pop = 2'd0;
      if (pack_load) begin
         pop = can_pair ? 2'd2 : 2'd1;
      end
      second_sample = can_pair ? fifo_head1 : '0;
      pack_word     = PACK_FIRST_LOW ? {second_sample, fifo_head0} : {fifo_head0, second_sample};
   end

   always_ff @(posedge mem_clk) begin
      if (!reset) begin
         length_reg    <= '0;
         issued_reg    <= '0;
         packed_reg    <= '0;
         addr_reg      <= '0;
         inflight_reg  <= 1'b0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
      end else begin
         inflight_reg <= rd_issue;
         if (accept_start) begin
            length_reg <= length;
            addr_reg   <= start_addr;
            issued_reg <= '0;
            packed_reg <= '0;
         end else if (rd_issue) begin
            addr_reg   <= addr_reg + AW'(1);
            issued_reg <= issued_reg + (AW+1)'(1);
         end
         if (abort) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
         end else if (pack_load) begin
            out_data_reg  <= pack_word;
            out_valid_reg <= 1'b1;
            out_last_reg  <= (remaining <= (AW+1)'(2));
            packed_reg    <= packed_reg + (AW+1)'(pop);
         end else if (out_ready) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
         end
      end
   end

   assign busy      = (state_reg == ST_RUN);
   assign done      = (state_reg == ST_FIN);
   assign ram_rd    = rd_issue;
   assign ram_addr  = addr_reg;
   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;
   assign out_last  = out_last_reg;

endmodule

// File: tb/tb_wfm_drain.sv
// Scoreboard bench for wfm_drain: a buffer model answers reads, expected words
// are queued at start and a negedge monitor checks every output cycle.
module tb_wfm_drain;

   localparam int AW    = 9;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int N     = 1 << AW;

   logic            mem_clk = 1'b0;
   logic            reset = 1'b0;
   logic            start = 1'b0;
   logic [AW-1:0]   start_addr = '0;
   logic [AW:0]     length = '0;
   logic            abort = 1'b0;
   logic            busy;
   logic            done;
   logic            ram_rd;
   logic [AW-1:0]   ram_addr;
   logic [DW-1:0]   ram_data = '0;
   logic [2*DW-1:0] out_data;
   logic            out_valid;
   logic            out_last;
   logic            out_ready = 1'b0;

   wfm_drain #(.AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH)) dut (
      .mem_clk    (mem_clk),
      .reset      (reset),
      .start      (start),
      .start_addr (start_addr),
      .length     (length),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .ram_rd     (ram_rd),
      .ram_addr   (ram_addr),
      .ram_data   (ram_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .out_ready  (out_ready)
   );

   always #5 mem_clk = ~mem_clk;

   logic [DW-1:0] ram_mem [N];
   always @(posedge mem_clk) begin
      if (ram_rd) ram_data <= ram_mem[ram_addr];
   end

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge mem_clk) cyc++;

   // Scoreboard and per-drain bookkeeping.
   logic [2*DW:0] exp_q[$];
   int  cur_start = 0, cur_len = 0, rd_cnt = 0, hs_samples = 0, hs_words = 0, stall_cnt = 0;
   int  done_exp_cyc = -1;
   bit  drain_active = 0, done_seen = 0;
   bit  prev_reset = 0, prev_abort = 0, prev_stall = 0;
   logic [2*DW-1:0] stall_data;
   logic            stall_last;
   int  ready_mode = 0;
   int  rcnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge mem_clk) begin
      #1;
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'($urandom_range(0, 1));
         2: begin out_ready = (rcnt % 4 == 0); rcnt++; end
         default: ;
      endcase
   end

   always @(negedge mem_clk) begin
      int cur;
      logic [2*DW:0] e;
      logic [AW-1:0] exp_addr;
      if (!reset) begin
         exp_q.delete();
         drain_active = 0;
         done_exp_cyc = -1;
         prev_reset = 1;
         prev_abort = 0;
         prev_stall = 0;
      end else begin
         if (prev_reset)
            chk("reset_outputs", {busy, done, ram_rd, out_valid, out_last, ram_addr, out_data}, 64'd0);
         if (prev_abort) begin
            chk("abort_valid", out_valid, 1'b0);
            chk("abort_busy", busy, 1'b0);
         end else if (prev_stall) begin
            chk("hold_stable", {out_valid, out_last, out_data}, {1'b1, stall_last, stall_data});
         end
         chk("done", done, (cyc == done_exp_cyc));
         if (done) begin
            chk("busy_in_done", busy, 1'b0);
            done_seen = 1;
         end
         if (ram_rd) begin
            exp_addr = AW'((cur_start + rd_cnt) % N);
            chk("rd_addr", {drain_active, (rd_cnt < cur_len), ram_addr}, {2'b11, exp_addr});
            rd_cnt++;
         end else if (busy && drain_active && rd_cnt < cur_len) begin
            stall_cnt++;
         end
         cur = out_valid ? ((out_last && cur_len[0]) ? 1 : 2) : 0;
         if (drain_active && busy)
            chk("outstanding", (rd_cnt - hs_samples - cur) <= DEPTH, 1'b1);
         if (out_valid && out_ready && !abort) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_word: got %0h expected none (cycle %0d)", out_data, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("word", {out_last, out_data}, e);
            end
            hs_samples += cur;
            hs_words++;
            if (out_last) done_exp_cyc = cyc + 1;
         end
         if (abort) begin
            exp_q.delete();
            drain_active = 0;
         end
         prev_abort = abort;
         prev_reset = 0;
         prev_stall = out_valid && !out_ready && !abort;
         stall_data = out_data;
         stall_last = out_last;
      end
   end

   // Reference: ceil(len/2) words, earlier sample low, odd tail zero-padded.
   task automatic push_expected(input int addr, input int len);
      logic [DW-1:0] lo, hi;
      for (int i = 0; i < len; i += 2) begin
         lo = ram_mem[(addr + i) % N];
         hi = (i + 1 < len) ? ram_mem[(addr + i + 1) % N] : '0;
         exp_q.push_back({(i + 2 >= len), hi, lo});
      end
   endtask

   task automatic do_start(input int addr, input int len);
      @(posedge mem_clk); #1;
      push_expected(addr, len);
      cur_start = addr; cur_len = len;
      rd_cnt = 0; hs_samples = 0; hs_words = 0; stall_cnt = 0;
      drain_active = 1; done_seen = 0;
      if (len == 0) done_exp_cyc = cyc + 1;
      start = 1'b1; start_addr = AW'(addr); length = (AW+1)'(len);
      @(posedge mem_clk); #1;
      start = 1'b0;
      if (len != 0) chk("busy_after_start", busy, 1'b1);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done_seen && n < budget) begin
         @(negedge mem_clk);
         n++;
      end
      total++;
      if (!done_seen) begin
         bad++;
         $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
      end
      @(negedge mem_clk);
      chk("busy_after_done", busy, 1'b0);
      chk("queue_empty", exp_q.size(), 0);
      chk("read_count", rd_cnt, cur_len);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < N; i++) ram_mem[i] = DW'(i);
      repeat (3) @(posedge mem_clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge mem_clk);

      ready_mode = 0;
      do_start(12'h010, 4);
      wait_done(100);
      chk("t1_words", hs_words, 2);

      for (int i = 0; i < N; i++) ram_mem[i] = DW'($urandom);

      do_start(12'h1FE, 3);
      wait_done(100);
      chk("t2_words", hs_words, 2);

      ready_mode = 2;
      do_start($urandom_range(0, N - 1), 8);
      wait_done(200);
      chk("t3_words", hs_words, 4);
      chk("t3_rd_stalled", (stall_cnt > 0), 1'b1);

      ready_mode = 0;
      do_start($urandom_range(0, N - 1), 0);
      wait_done(20);
      chk("t4_words", hs_words, 0);

      do_start(100, 16);
      n = 0;
      while (hs_words < 2 && n < 200) begin
         @(negedge mem_clk);
         n++;
      end
      chk("t5_reached_two", (hs_words >= 2), 1'b1);
      ready_mode = 3;
      @(posedge mem_clk); #1;
      out_ready = 1'b0;
      abort = 1'b1;
      @(posedge mem_clk); #1;
      abort = 1'b0;
      repeat (4) @(posedge mem_clk);
      ready_mode = 0;
      do_start(12'h040, 2);
      wait_done(100);
      chk("t5_restart_words", hs_words, 1);

      ready_mode = 1;
      do_start(300, 20);
      repeat (4) @(posedge mem_clk);
      #1 start = 1'b1; start_addr = AW'(7); length = (AW+1)'(5);
      @(posedge mem_clk); #1 start = 1'b0;
      wait_done(400);
      chk("t6_ignored_start_words", hs_words, 10);

      do_start(200, 30);
      repeat (8) @(posedge mem_clk);
      #1 reset = 1'b0;
      @(posedge mem_clk); #1 reset = 1'b1;
      repeat (4) @(posedge mem_clk);

      for (int t = 0; t < 10; t++) begin
         ready_mode = $urandom_range(0, 2);
         n = $urandom_range(0, 40);
         do_start($urandom_range(0, N - 1), n);
         wait_done(8 * n + 50);
      end

      ready_mode = 1;
      do_start($urandom_range(0, N - 1), N);
      wait_done(8 * N + 50);
      chk("full_words", hs_words, N / 2);

      repeat (5) @(posedge mem_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
